wrr_vc_arbiter: RTL and testbench
=================================

// Module: wrr_vc_arbiter
// PURPOSE
//  Parametrised weighted round-robin arbiter draining NUM_VC virtual-channel FWFT FIFOs into one output.
//  Sits between the VC FIFO bank and the single downstream FIFO.
//  Each channel is served for up to weight[i] words per turn, then the pointer rotates.
//  Honours downstream backpressure (out_full) and a global enable (enb).
// PARAMETERS
//  NUM_VC  4  number of virtual channels (>=2)
//  DATA_W  4  word width per channel
//  WGT_W   4  weight width; weight range 0..2**WGT_W-1, 0 = channel disabled
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  enb        in   1              arbitration/pop enable; low = freeze, no state change
//  empty_vc   in   NUM_VC         per-channel FIFO empty flag
//  data_vc    in   NUM_VC*DATA_W  per-channel FWFT head word, channel i at [i*DATA_W +: DATA_W]
//  weight_vc  in   NUM_VC*WGT_W   per-channel weight, channel i at [i*WGT_W +: WGT_W]
//  out_full   in   1              downstream full; high = no pop this cycle
//  pop_vc     out  NUM_VC         one-hot-or-zero pop to channel FIFOs (combinational)
//  out_data   out  DATA_W         registered output word
//  out_valid  out  1              out_data valid this cycle (1-cycle pulse per word)
//  grant_id   out  clog2(NUM_VC)  channel currently granted (registered)
//  busy       out  1              high while in SERVE
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, ptr=0, grant_id=0, credit=0, out_data=0, out_valid=0, busy=0.
//   pop_vc=0 while rst is high.
//  eligible[i] = !empty_vc[i] && weight_vc[i]!=0.
//  IDLE: if enb && !out_full && |eligible:
//   - pick the first eligible channel at or after ptr (wrap NUM_VC-1 -> 0);
//   - next state is SERVE, with grant_id=pick and credit=weight_vc[pick]
//     (weight sampled only here; changes mid-turn take effect on the next turn).
//   - No pop in the IDLE cycle. Else stay in IDLE.
//  SERVE: pop_vc[grant_id] = enb && !out_full && !empty_vc[grant_id] && credit!=0.
//   - On a pop: out_data <= head word, out_valid <= 1, credit <= credit-1.
//     out_valid appears 1 cycle after pop; pop-to-out latency is 1 cycle.
//   - Pop with credit==1: go to IDLE, ptr <= grant_id+1 (mod NUM_VC).
//   - enb && !out_full && empty_vc[grant_id]: go to IDLE, ptr <= grant_id+1. Unused credit is discarded.
//   - !enb or out_full: hold state, credit, grant_id. No pop, out_valid <= 0.
//  out_valid is 0 in every cycle without a pop. out_data holds its last value.
//  Switching channels always costs exactly one bubble cycle (the IDLE arbitration cycle).
//  All weights 0, or all channels empty: stay in IDLE, no pops, ptr unchanged.
//  A single eligible channel is re-granted after its bubble. Throughput is w/(w+1).
//  Reset mid-SERVE: abandon the turn immediately. The in-flight word is not replayed.
//  Counters are WGT_W bits wide and never underflow: the credit==0 pop guard makes this so.
// STRUCTURE
//  Shared package/include vc_pkg:
//   - state encoding ST_IDLE/ST_SERVE
//   - clog2 function
//   - default NUM_VC/DATA_W/WGT_W constants
//  Sub-module rr_pointer_pick: combinational rotating first-one finder.
//   - inputs: req[NUM_VC], ptr
//   - outputs: pick index, any
//  Top module holds the FSM, credit counter, pointer and output registers.
// TESTING
//  1. Weights {1,1,1,1}, all FIFOs full of tagged words, out_full=0:
//     out sequence ch0,ch1,ch2,ch3,ch0..., one bubble between words.
//  2. Weights {3,1,2,0}, all non-empty: per round, 3 words ch0, 1 ch1, 2 ch2, none ch3.
//     grant_id sequence 0,1,2,0.
//  3. ch1 weight 4 with 2 words queued: 2 pops, then empty -> IDLE, ptr=2. Credit 2 discarded.
//  4. out_full high for 5 cycles mid-turn (credit=2): no pops, credit/grant held.
//     After release, 2 more pops, then rotate.
//  5. Assert rst during SERVE: same cycle pop_vc=0, out_valid=0.
//     After release, IDLE; first grant goes to lowest eligible index >= 0.
//  6. NUM_VC=8, DATA_W=8 instance, only ch7 eligible, weight 2: pops ch7 x2, bubble, repeats.
//     ptr wraps 7 -> 0.

Source files
------------

// File: rtl/vc_pkg.sv
// Shared definitions for the weighted round-robin VC arbiter.
package vc_pkg;

   localparam int unsigned NUM_VC_DEF = 4;
   localparam int unsigned DATA_W_DEF = 4;
   localparam int unsigned WGT_W_DEF  = 4;

   typedef enum logic {
      ST_IDLE,
      ST_SERVE
   } arb_state_e;

   // Ceiling log2, minimum 1 so a 2-channel arbiter still gets a 1-bit index.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pointer_pick.sv
// Rotating first-one finder: first set request at or after ptr, wrapping to 0.
module rr_pointer_pick
   import vc_pkg::*;
#(
   parameter int unsigned NUM_VC = NUM_VC_DEF
) (
   input  logic [NUM_VC-1:0]        req,
   input  logic [clog2(NUM_VC)-1:0] ptr,
   output logic [clog2(NUM_VC)-1:0] pick,
   output logic                     any
);

   localparam int unsigned IDX_W = clog2(NUM_VC);

   // Scan NUM_VC positions starting at ptr; the first hit wins.
   always_comb begin
      pick = '0;
      any  = 1'b0;
      for (int unsigned k = 0; k < NUM_VC; k++) begin
         int unsigned      idx;
         logic [IDX_W-1:0] idx_t;
         idx = 32'(ptr) + k;
         if (idx >= NUM_VC) idx = idx - NUM_VC;
         idx_t = IDX_W'(idx);
         if (!any && req[idx_t]) begin
            any  = 1'b1;
            pick = idx_t;
         end
      end
   end

endmodule

// File: rtl/wrr_vc_arbiter.sv
// Weighted round-robin arbiter draining NUM_VC FWFT FIFOs into one output.
module wrr_vc_arbiter
   import vc_pkg::*;
#(
   parameter int unsigned NUM_VC = NUM_VC_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned WGT_W  = WGT_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enb,
   input  logic [NUM_VC-1:0]         empty_vc,
   input  logic [NUM_VC*DATA_W-1:0]  data_vc,
   input  logic [NUM_VC*WGT_W-1:0]   weight_vc,
   input  logic                      out_full,
   output logic [NUM_VC-1:0]         pop_vc,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
   output logic [clog2(NUM_VC)-1:0]  grant_id,
   output logic                      busy
);

   localparam int unsigned IDX_W = clog2(NUM_VC);

   arb_state_e       state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt, grant_nxt, grant_inc, pick;
   logic [WGT_W-1:0] credit, credit_nxt;
   logic [NUM_VC-1:0] eligible;
   logic             any, go, pop;

   // A channel competes only if it has data and a non-zero weight.
   always_comb begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
         eligible[i] = !empty_vc[i] && (weight_vc[i*WGT_W +: WGT_W] != '0);
      end
   end

   rr_pointer_pick #(
      .NUM_VC(NUM_VC)
   ) u_pick (
      .req  (eligible),
      .ptr  (ptr),
      .pick (pick),
      .any  (any)
   );

   assign go        = enb && !out_full;
   assign grant_inc = (grant_id == IDX_W'(NUM_VC - 1)) ? '0 : grant_id + IDX_W'(1);
   assign busy      = (state == ST_SERVE);

   // Next-state, credit, pointer and pop decode.
   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      grant_nxt  = grant_id;
      credit_nxt = credit;
      pop        = 1'b0;
      pop_vc     = '0;
      case (state)
         ST_IDLE: begin
            if (go && any) begin
               state_nxt  = ST_SERVE;
               grant_nxt  = pick;
               credit_nxt = weight_vc[32'(pick)*WGT_W +: WGT_W];
            end
         end
         ST_SERVE: begin
            if (go) begin
               if (!empty_vc[grant_id] && credit != '0) begin
                  pop        = !rst;
                  credit_nxt = credit - WGT_W'(1);
                  if (credit == WGT_W'(1)) begin
                     state_nxt = ST_IDLE;
                     ptr_nxt   = grant_inc;
                  end
               end else begin
                  // Channel ran dry (or no credit): end the turn, drop leftover credit.
                  state_nxt = ST_IDLE;
                  ptr_nxt   = grant_inc;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      pop_vc[grant_id] = pop;
   end

   // Arbitration state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         grant_id <= '0;
         credit   <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         grant_id <= grant_nxt;
         credit   <= credit_nxt;
      end
   end

   // Output word register: captures the popped head word, valid for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= pop;
         if (pop) out_data <= data_vc[32'(grant_id)*DATA_W +: DATA_W];
      end
   end

endmodule

// File: tb/tb_wrr_vc_arbiter.sv
// Directed scoreboard bench for wrr_vc_arbiter (4-VC instance plus an 8-VC instance).
module tb_wrr_vc_arbiter;

   localparam int unsigned NV = 4;
   localparam int unsigned DW = 4;
   localparam int unsigned WW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, enb, out_full;
   logic [NV-1:0]  empty_vc, pop_vc;
   logic [NV*DW-1:0] data_vc;
   logic [NV*WW-1:0] weight_vc;
   logic [DW-1:0]  out_data;
   logic           out_valid;
   logic [1:0]     grant_id;
   logic           busy;

   logic [7:0]  empty8, pop8, out_data8;
   logic [63:0] data8;
   logic [31:0] weight8;
   logic        out_full8, out_valid8, busy8;
   logic [2:0]  grant8;

   wrr_vc_arbiter #(.NUM_VC(NV), .DATA_W(DW), .WGT_W(WW)) dut (
      .clk(clk), .rst(rst), .enb(enb), .empty_vc(empty_vc), .data_vc(data_vc),
      .weight_vc(weight_vc), .out_full(out_full), .pop_vc(pop_vc), .out_data(out_data),
      .out_valid(out_valid), .grant_id(grant_id), .busy(busy)
   );

   wrr_vc_arbiter #(.NUM_VC(8), .DATA_W(8), .WGT_W(4)) dut8 (
      .clk(clk), .rst(rst), .enb(enb), .empty_vc(empty8), .data_vc(data8),
      .weight_vc(weight8), .out_full(out_full8), .pop_vc(pop8), .out_data(out_data8),
      .out_valid(out_valid8), .grant_id(grant8), .busy(busy8)
   );

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] fq [NV][$];
   logic [DW-1:0] sb [$];
   logic [NV-1:0] popped;
   logic [7:0]    popped8;
   logic          prev_valid = 1'b0;
   int            b2b = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] word(input int c, input int n);
      logic [1:0] cc, nn;
      cc = c[1:0];
      nn = n[1:0];
      return {cc, nn};
   endfunction

   task automatic drive();
      for (int i = 0; i < NV; i++) begin
         if (fq[i].size() == 0) begin
            empty_vc[i] = 1'b1;
            data_vc[i*DW +: DW] = '0;
         end else begin
            empty_vc[i] = 1'b0;
            data_vc[i*DW +: DW] = fq[i][0];
         end
      end
   endtask

   // Called at posedge+1; returns at the next posedge+1 with outputs checked.
   task automatic tick();
      logic [DW-1:0] exp;
      drive();
      #8;
      popped  = pop_vc;
      popped8 = pop8;
      @(posedge clk);
      #1;
      if (popped != '0) chk("pop_onehot", ($countones(popped) == 1), 1);
      for (int i = 0; i < NV; i++) begin
         if (popped[i]) begin
            chk("pop_on_nonempty", (fq[i].size() != 0), 1);
            if (fq[i].size() != 0) void'(fq[i].pop_front());
         end
      end
      drive();
      if (out_valid) begin
         chk("word_expected", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk("out_data", out_data, exp);
            chk("word_channel", grant_id, exp[3:2]);
         end
         if (prev_valid) b2b++;
      end
      prev_valid = out_valid;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enb = 1'b1; out_full = 1'b0; out_full8 = 1'b0;
      weight_vc = '0; weight8 = '0; empty8 = 8'hFF; data8 = '0;
      drive();
      @(posedge clk); #1;
      @(posedge clk); #1;
      // Reset state
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_pop", pop_vc, 0);
      chk("rst_busy8", busy8, 0);
      rst = 1'b0;

      // 1: equal weights, round robin with one bubble between words
      weight_vc = {4'd1, 4'd1, 4'd1, 4'd1};
      for (int c = 0; c < 4; c++) for (int n = 0; n < 4; n++) fq[c].push_back(word(c, n));
      for (int n = 0; n < 4; n++) for (int c = 0; c < 4; c++) sb.push_back(word(c, n));
      b2b = 0;
      repeat (34) tick();
      chk("t1_drained", sb.size(), 0);
      chk("t1_bubble", b2b, 0);
      chk("t1_idle", busy, 0);

      // 2: weights {3,1,2,0}
      weight_vc = {4'd0, 4'd2, 4'd1, 4'd3};
      for (int n = 0; n < 6; n++) fq[0].push_back(word(0, n));
      for (int n = 0; n < 4; n++) fq[1].push_back(word(1, n));
      for (int n = 0; n < 4; n++) fq[2].push_back(word(2, n));
      for (int n = 0; n < 2; n++) fq[3].push_back(word(3, n));
      for (int n = 0; n < 3; n++) sb.push_back(word(0, n));
      sb.push_back(word(1, 0));
      for (int n = 0; n < 2; n++) sb.push_back(word(2, n));
      for (int n = 3; n < 6; n++) sb.push_back(word(0, n));
      sb.push_back(word(1, 1));
      for (int n = 2; n < 4; n++) sb.push_back(word(2, n));
      sb.push_back(word(1, 2));
      sb.push_back(word(1, 3));
      repeat (32) tick();
      chk("t2_drained", sb.size(), 0);
      chk("t2_ch3_untouched", fq[3].size(), 2);
      fq[3].delete();

      // 3: weight 4 with only 2 words queued; turn ends on empty, ptr -> 2
      weight_vc = {4'd4, 4'd4, 4'd4, 4'd4};
      fq[1].push_back(word(1, 0)); fq[1].push_back(word(1, 1));
      sb.push_back(word(1, 0)); sb.push_back(word(1, 1));
      tick();
      chk("t3_granted", busy, 1);
      chk("t3_grant_id", grant_id, 1);
      tick(); tick();
      chk("t3_serving", busy, 1);
      tick();
      chk("t3_idle_on_empty", busy, 0);
      fq[1].push_back(word(1, 2)); fq[3].push_back(word(3, 0));
      sb.push_back(word(3, 0)); sb.push_back(word(1, 2));
      repeat (8) tick();
      chk("t3_drained", sb.size(), 0);

      // 4: backpressure and enable freeze mid-turn with credit 2
      for (int n = 0; n < 6; n++) fq[0].push_back(word(0, n));
      fq[1].push_back(word(1, 3));
      for (int n = 0; n < 4; n++) sb.push_back(word(0, n));
      sb.push_back(word(1, 3));
      sb.push_back(word(0, 4)); sb.push_back(word(0, 5));
      repeat (3) tick();
      out_full = 1'b1;
      repeat (5) begin
         tick();
         chk("t4_full_no_pop", popped, 0);
      end
      chk("t4_full_busy", busy, 1);
      chk("t4_full_grant", grant_id, 0);
      out_full = 1'b0;
      tick();
      enb = 1'b0;
      repeat (2) begin
         tick();
         chk("t4_enb_no_pop", popped, 0);
         chk("t4_enb_busy", busy, 1);
      end
      enb = 1'b1;
      repeat (12) tick();
      chk("t4_drained", sb.size(), 0);

      // 5: reset during SERVE
      weight_vc = {4'd3, 4'd3, 4'd3, 4'd3};
      for (int n = 0; n < 3; n++) fq[2].push_back(word(2, n));
      fq[0].push_back(word(0, 0)); fq[0].push_back(word(0, 1));
      sb.push_back(word(2, 0));
      tick(); tick();
      chk("t5_pop_before_rst", pop_vc, 4'b0100);
      rst = 1'b1;
      #1;
      chk("t5_rst_pop", pop_vc, 0);
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_grant", grant_id, 0);
      @(posedge clk); #1;
      prev_valid = 1'b0;
      rst = 1'b0;
      sb.push_back(word(0, 0)); sb.push_back(word(0, 1));
      sb.push_back(word(2, 1)); sb.push_back(word(2, 2));
      tick();
      chk("t5_first_grant", grant_id, 0);
      chk("t5_first_busy", busy, 1);
      repeat (10) tick();
      chk("t5_drained", sb.size(), 0);

      // 6: 8-VC instance, only ch7 eligible, weight 2; then ptr wraps to ch0
      weight8 = {8{4'd2}};
      data8   = '0;
      data8[63:56] = 8'hA7;
      empty8  = 8'h7F;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t6_pop_pattern", popped8, (k % 3 == 0) ? 8'h00 : 8'h80);
         if (k == 0) chk("t6_grant7", grant8, 7);
         if (k == 1) begin
            chk("t6_valid", out_valid8, 1);
            chk("t6_data", out_data8, 8'hA7);
         end
      end
      data8[7:0] = 8'h5C;
      empty8 = 8'h7E;
      tick();
      chk("t6_wrap_grant", grant8, 0);
      tick();
      chk("t6_wrap_pop", popped8, 8'h01);
      chk("t6_wrap_data", out_data8, 8'h5C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
